branch_resolve_unit: RTL and testbench

- EX-stage branch resolution block, directly downstream of the branch comparator.
- Drives the comparator's unsigned-select input and consumes its equal/less-than flags.
- Evaluates the branch/jump condition against static not-taken prediction, then issues a registered PC redirect and a timed pipeline flush.
- Keeps saturating branch and mispredict performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 22 ++
 rtl/branch_resolve_unit_if.sv | 32 +++
 rtl/branch_resolve_unit_cond.sv | 29 ++
 rtl/branch_resolve_unit.sv | 158 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and types for the EX-stage branch resolution slice.
// Imported by the condition decoder and the resolution top level.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brState_e;

  // Fetch only handles 4-byte aligned targets, so bit 1 set is a fault.
  function automatic logic targetMisaligned(input logic [1:0] lowBits);
    return lowBits[1];
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage bundle between the pipeline/comparator and the branch resolver.
// master = EX stage and comparator side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);

  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            br_eq;
  logic            br_lt;
  logic            br_un;
  logic            stall_in;

  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
    output ex_pc, ex_imm, ex_rs1, br_eq, br_lt, stall_in,
    input  br_un
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
    input  ex_pc, ex_imm, ex_rs1, br_eq, br_lt, stall_in,
    output br_un
  );

endinterface

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch condition decoder: funct3 plus comparator flags
// give taken/illegal, and funct3 alone selects unsigned comparison.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] ex_funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un,
  output logic       illegal
);

  // Decode the taken condition; 010/011 have no branch meaning.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (ex_funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = ~br_eq;
      F3_BLT, F3_BLTU:  taken = br_lt;
      F3_BGE, F3_BGEU:  taken = ~br_lt;
      default:          illegal = 1'b1;
    endcase
  end

  assign br_un = (ex_funct3 == F3_BLTU) || (ex_funct3 == F3_BGEU);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: not-taken static prediction, registered
// redirect, timed IF/ID + ID/EX flush and saturating perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  branch_resolve_unit_if.slave exIf,
  input  logic                perf_clr,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                misalign_exc,
  output logic                illegal_branch,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispredict_cnt
);

  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_FLUSH   = FLUSH;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]      state_r;
  logic [3:0]      flushCnt_r;
  logic            flush_r;

  logic            condTaken_s;
  logic            condIllegal_s;
  logic            condUn_s;
  logic            resolve_s;
  logic            legal_s;
  logic            taken_s;
  logic            illegalHit_s;
  logic            misaligned_s;
  logic            doRedirect_s;
  logic            doMisalign_s;
  logic [XLEN-1:0] pcSum_s;
  logic [XLEN-1:0] jalrSum_s;
  logic [XLEN-1:0] target_s;

  branch_cond uCond (
    .ex_funct3 (exIf.ex_funct3),
    .br_eq     (exIf.br_eq),
    .br_lt     (exIf.br_lt),
    .taken     (condTaken_s),
    .br_un     (condUn_s),
    .illegal   (condIllegal_s)
  );

  assign exIf.br_un = condUn_s;

  // Shadow instructions behind a redirect never resolve: IDLE only.
  assign resolve_s = exIf.ex_valid & ~exIf.stall_in & (state_r == ST_IDLE);
  assign pcSum_s   = exIf.ex_pc + exIf.ex_imm;
  assign jalrSum_s = exIf.ex_rs1 + exIf.ex_imm;

  // Classify the EX instruction with JAL > JALR > branch priority.
  always_comb begin
    legal_s      = 1'b0;
    taken_s      = 1'b0;
    illegalHit_s = 1'b0;
    target_s     = pcSum_s;
    if (exIf.ex_is_jal) begin
      legal_s = 1'b1;
      taken_s = 1'b1;
    end else if (exIf.ex_is_jalr) begin
      legal_s  = 1'b1;
      taken_s  = 1'b1;
      target_s = {jalrSum_s[XLEN-1:1], 1'b0};
    end else if (exIf.ex_is_branch) begin
      legal_s      = ~condIllegal_s;
      taken_s      = condTaken_s & ~condIllegal_s;
      illegalHit_s = condIllegal_s;
    end else begin
      legal_s = 1'b0;
    end
  end

  assign misaligned_s = targetMisaligned(target_s[1:0]);
  assign doRedirect_s = resolve_s & taken_s & ~misaligned_s;
  assign doMisalign_s = resolve_s & taken_s & misaligned_s;

  // Redirect/exception pulses, redirect target and flush FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      flushCnt_r     <= 4'd0;
      flush_r        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= {XLEN{1'b0}};
      misalign_exc   <= 1'b0;
      illegal_branch <= 1'b0;
    end else begin
      redirect_valid <= doRedirect_s;
      misalign_exc   <= doMisalign_s;
      illegal_branch <= resolve_s & illegalHit_s;
      if (doRedirect_s) begin
        redirect_pc <= target_s;
      end else begin
        redirect_pc <= redirect_pc;
      end
      case (state_r)
        ST_IDLE: begin
          if (doRedirect_s) begin
            state_r    <= ST_FLUSH;
            flushCnt_r <= FLUSH_LOAD;
            flush_r    <= 1'b1;
          end else begin
            flush_r    <= 1'b0;
          end
        end
        // The countdown ignores stall_in: a flush must always complete.
        ST_FLUSH: begin
          if (flushCnt_r == 4'd0) begin
            state_r <= ST_IDLE;
            flush_r <= 1'b0;
          end else begin
            flushCnt_r <= flushCnt_r - 4'd1;
            flush_r    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  assign flush_if_id = flush_r;
  assign flush_id_ex = flush_r;

  // Saturating performance counters; perf_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      branch_cnt     <= {CNT_W{1'b0}};
      mispredict_cnt <= {CNT_W{1'b0}};
    end else begin
      if (resolve_s && legal_s && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end else begin
        branch_cnt <= branch_cnt;
      end
      if (doRedirect_s && (mispredict_cnt != CNT_MAX)) begin
        mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end else begin
        mispredict_cnt <= mispredict_cnt;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench: two instances (32-bit and 4-bit counters)
// driven identically; a reference model queues the expected outputs.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  typedef struct {
    logic        rst, valid, isBr, isJal, isJalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, lt, stall, clr;
  } stim_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        flush, mis, ill;
    logic [31:0] bcA, mcA;
    logic [3:0]  bcB, mcB;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, perfClr;
  logic rvA, fiA, feA, misA, illA, rvB, fiB, feB, misB, illB;
  logic [31:0] rpcA, rpcB, bcA, mcA;
  logic [3:0]  bcB, mcB;

  branch_resolve_unit_if #(.XLEN(XLEN)) busA ();
  branch_resolve_unit_if #(.XLEN(XLEN)) busB ();

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(32)) dutA (
    .clk(clk), .rst(rst), .exIf(busA), .perf_clr(perfClr),
    .redirect_valid(rvA), .redirect_pc(rpcA), .flush_if_id(fiA), .flush_id_ex(feA),
    .misalign_exc(misA), .illegal_branch(illA), .branch_cnt(bcA), .mispredict_cnt(mcA)
  );

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .exIf(busB), .perf_clr(perfClr),
    .redirect_valid(rvB), .redirect_pc(rpcB), .flush_if_id(fiB), .flush_id_ex(feB),
    .misalign_exc(misB), .illegal_branch(illB), .branch_cnt(bcB), .mispredict_cnt(mcB)
  );

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  int          mState, mCnt;
  logic        mFlush;
  logic [31:0] mRpc, mBcA, mMcA;
  logic [3:0]  mBcB, mMcB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{rst:1'b0, valid:1'b0, isBr:1'b0, isJal:1'b0, isJalr:1'b0, f3:3'd0,
          pc:32'd0, imm:32'd0, rs1:32'd0, eq:1'b0, lt:1'b0, stall:1'b0, clr:1'b0};
    return s;
  endfunction

  function automatic stim_t br(input logic [2:0] f3, input logic [31:0] pc, imm,
                               input logic eq, lt);
    stim_t s = nop();
    s.valid = 1'b1; s.isBr = 1'b1; s.f3 = f3; s.pc = pc; s.imm = imm; s.eq = eq; s.lt = lt;
    return s;
  endfunction

  function automatic stim_t jal(input logic [31:0] pc, imm);
    stim_t s = nop();
    s.valid = 1'b1; s.isJal = 1'b1; s.pc = pc; s.imm = imm;
    return s;
  endfunction

  function automatic stim_t jalr(input logic [31:0] rs1, imm);
    stim_t s = nop();
    s.valid = 1'b1; s.isJalr = 1'b1; s.rs1 = rs1; s.imm = imm;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; perfClr = s.clr;
    busA.ex_valid = s.valid; busA.ex_is_branch = s.isBr; busA.ex_is_jal = s.isJal;
    busA.ex_is_jalr = s.isJalr; busA.ex_funct3 = s.f3; busA.ex_pc = s.pc;
    busA.ex_imm = s.imm; busA.ex_rs1 = s.rs1; busA.br_eq = s.eq; busA.br_lt = s.lt;
    busA.stall_in = s.stall;
    busB.ex_valid = s.valid; busB.ex_is_branch = s.isBr; busB.ex_is_jal = s.isJal;
    busB.ex_is_jalr = s.isJalr; busB.ex_funct3 = s.f3; busB.ex_pc = s.pc;
    busB.ex_imm = s.imm; busB.ex_rs1 = s.rs1; busB.br_eq = s.eq; busB.br_lt = s.lt;
    busB.stall_in = s.stall;
  endtask

  // Reference model: one clock of architectural behaviour.
  task automatic modelStep(input stim_t s, output exp_t e);
    logic take, legal, ill;
    logic [31:0] tgt;
    take = 1'b0; legal = 1'b0; ill = 1'b0; tgt = 32'd0;
    e.rv = 1'b0; e.mis = 1'b0; e.ill = 1'b0;
    if (s.rst) begin
      mState = 0; mCnt = 0; mFlush = 1'b0; mRpc = 32'd0;
      mBcA = 32'd0; mMcA = 32'd0; mBcB = 4'd0; mMcB = 4'd0;
    end else begin
      if (mState == 1) begin
        if (mCnt == 0) begin mState = 0; mFlush = 1'b0; end
        else mCnt = mCnt - 1;
      end else begin
        mFlush = 1'b0;
        if (s.valid && !s.stall) begin
          if (s.isJal) begin
            legal = 1'b1; take = 1'b1; tgt = s.pc + s.imm;
          end else if (s.isJalr) begin
            legal = 1'b1; take = 1'b1; tgt = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
          end else if (s.isBr) begin
            tgt   = s.pc + s.imm;
            ill   = (s.f3 == 3'b010) || (s.f3 == 3'b011);
            legal = !ill;
            if (!ill) take = s.f3[0] ^ (s.f3[2] ? s.lt : s.eq);
          end
          e.ill = ill;
          if (take) begin
            if (tgt[1]) e.mis = 1'b1;
            else begin
              e.rv = 1'b1; mRpc = tgt; mState = 1; mCnt = FC - 1; mFlush = 1'b1;
            end
          end
        end
      end
      if (s.clr) begin
        mBcA = 32'd0; mMcA = 32'd0; mBcB = 4'd0; mMcB = 4'd0;
      end else begin
        if (legal) begin
          if (mBcA != 32'hFFFF_FFFF) mBcA = mBcA + 32'd1;
          if (mBcB != 4'hF) mBcB = mBcB + 4'd1;
        end
        if (e.rv) begin
          if (mMcA != 32'hFFFF_FFFF) mMcA = mMcA + 32'd1;
          if (mMcB != 4'hF) mMcB = mMcB + 4'd1;
        end
      end
    end
    e.flush = mFlush; e.rpc = mRpc;
    e.bcA = mBcA; e.mcA = mMcA; e.bcB = mBcB; e.mcB = mMcB;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic expUn;
    drive(s);
    modelStep(s, e);
    expQ.push_back(e);
    expUn = (s.f3 == 3'b110) || (s.f3 == 3'b111);
    #1;
    chk("br_un_A", {31'd0, busA.br_un}, {31'd0, expUn});
    chk("br_un_B", {31'd0, busB.br_un}, {31'd0, expUn});
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      chk("redirect_valid", {31'd0, rvA}, {31'd0, e.rv});
      chk("redirect_pc", rpcA, e.rpc);
      chk("flush_if_id", {31'd0, fiA}, {31'd0, e.flush});
      chk("flush_id_ex", {31'd0, feA}, {31'd0, e.flush});
      chk("misalign_exc", {31'd0, misA}, {31'd0, e.mis});
      chk("illegal_branch", {31'd0, illA}, {31'd0, e.ill});
      chk("branch_cnt", bcA, e.bcA);
      chk("mispredict_cnt", mcA, e.mcA);
      chk("redirect_valid_B", {31'd0, rvB}, {31'd0, e.rv});
      chk("flush_B", {31'd0, fiB & feB}, {31'd0, e.flush});
      chk("misalign_B", {31'd0, misB}, {31'd0, e.mis});
      chk("illegal_B", {31'd0, illB}, {31'd0, e.ill});
      chk("branch_cnt_B", {28'd0, bcB}, {28'd0, e.bcB});
      chk("mispredict_cnt_B", {28'd0, mcB}, {28'd0, e.mcB});
    end
  endtask

  initial begin
    stim_t s;
    mState = 0; mCnt = 0; mFlush = 1'b0; mRpc = 32'd0;
    mBcA = 32'd0; mMcA = 32'd0; mBcB = 4'd0; mMcB = 4'd0;

    // Reset state.
    s = nop(); s.rst = 1'b1;
    step(s); step(s);
    step(nop());

    // Taken BEQ: redirect to 0x120, two flush cycles.
    step(br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0));
    step(nop()); step(nop()); step(nop());

    // Not-taken BNE after clearing counters; BLTU selects unsigned compare.
    s = nop(); s.clr = 1'b1; step(s);
    step(br(3'b001, 32'h200, 32'h40, 1'b1, 1'b0));
    step(br(3'b110, 32'h200, 32'h40, 1'b0, 1'b0));
    step(br(3'b111, 32'h200, 32'h40, 1'b0, 1'b1));

    // JALR clears bit 0; bit 1 set is a misalign fault.
    step(jalr(32'h1003, 32'h0));
    step(nop()); step(nop());
    step(jalr(32'h1002, 32'h0));
    step(nop());

    // Taken BLT with a valid BEQ in its shadow.
    step(br(3'b100, 32'h300, 32'h10, 1'b0, 1'b1));
    step(br(3'b000, 32'h400, 32'h80, 1'b1, 1'b0));
    step(br(3'b000, 32'h400, 32'h80, 1'b1, 1'b0));
    step(nop());

    // Stall held through the flush window does not extend it.
    step(br(3'b101, 32'h500, 32'hFFFF_FFF0, 1'b0, 1'b0));
    s = br(3'b000, 32'h600, 32'h8, 1'b1, 1'b0); s.stall = 1'b1;
    step(s); step(s); step(s);
    step(nop());

    // Reset in the first flush cycle.
    step(jal(32'h700, 32'h100));
    s = nop(); s.rst = 1'b1; step(s);
    step(nop());

    // Illegal funct3, and JAL priority over a same-cycle illegal branch flag.
    step(br(3'b010, 32'h800, 32'h4, 1'b1, 1'b1));
    step(br(3'b011, 32'h800, 32'h4, 1'b0, 1'b0));
    s = jal(32'h900, 32'h40); s.isBr = 1'b1; s.f3 = 3'b011; step(s);
    step(nop()); step(nop());

    // Stall in IDLE: no resolution.
    s = br(3'b000, 32'hA00, 32'h4, 1'b1, 1'b0); s.stall = 1'b1; step(s);

    // Target wrap-around and a misaligned branch target.
    step(br(3'b000, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0));
    step(nop()); step(nop());
    step(br(3'b001, 32'h100, 32'h2, 1'b0, 1'b0));
    step(jal(32'h100, 32'hFFFF_FFFE));

    // Saturate the 4-bit counters, then clear alongside a taken branch.
    for (int i = 0; i < 17; i++) begin
      step(br(3'b000, 32'h1000 + 32'(i * 16), 32'h40, 1'b1, 1'b0));
      step(nop()); step(nop());
    end
    s = br(3'b000, 32'h2000, 32'h40, 1'b1, 1'b0); s.clr = 1'b1; step(s);
    step(nop()); step(nop());
    step(jal(32'h3000, 32'h8));
    step(nop()); step(nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
